lm_writeback_seq: RTL and testbench
===================================

LM_WRITEBACK_SEQ -- requirements
Module: lm_writeback_seq

Interface
REQ-001 The block SHALL have the following ports:
- clk  in  1  sole clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  load-multiple request; sampled only in IDLE.
- base  in  16  first memory word address; latched on accepted start.
- mask  in  8  register select; bit i selects register i.
- flush  in  1  synchronous abort.
- mem_rd  out  1  memory read strobe.
- mem_addr  out  16  memory read address.
- mem_rdata  in  16  read data, valid the cycle after mem_rd.
- we3  out  1  register-file write enable.
- wa3  out  3  register-file write address.
- wd3  out  16  register-file write data.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- count  out  4  number of registers written by the last or current operation.

Function
REQ-002 States SHALL be IDLE, SCAN, WAIT and DONE, held in a state register updated on the rising edge of clk.
REQ-003 In IDLE with start=1, the block SHALL:
- latch base into the address register;
- latch mask[7:1] into the pending register, discarding mask[0] because r0 holds the PC;
- clear count;
- enter SCAN.
REQ-004 A start while not in IDLE SHALL be ignored, with no change to the latched base or pending.
REQ-005 In SCAN with pending=0, the block SHALL enter DONE without a memory read.
REQ-006 In SCAN with pending!=0, the block SHALL:
- select idx = the lowest set bit of pending;
- drive mem_rd=1 and mem_addr = the address register;
- enter WAIT.
REQ-007 In WAIT, the block SHALL drive we3=1, wa3=idx and wd3=mem_rdata. On the closing edge it SHALL:
- clear pending[idx];
- increment the address by 1 modulo 2^16, so 16'hFFFF wraps to 16'h0000;
- increment count;
- return to SCAN.
REQ-008 Registers SHALL be written in ascending index order, one write per two cycles, from consecutive memory words starting at base.
REQ-009 In DONE, the block SHALL assert done=1 for exactly one cycle, then enter IDLE. count SHALL hold its value until the next accepted start.
REQ-010 Outside SCAN, mem_rd SHALL be 0. Outside WAIT, the outputs SHALL be we3=0, wa3=3'd0 and wd3=16'h0000.
REQ-011 mem_addr SHALL always equal the address register.
REQ-012 Latency: with k selected registers (mask[7:1] popcount) and start sampled at edge E0, done SHALL be high in cycle 2k+2 after E0, and busy SHALL be high in cycles 1 through 2k+2.
REQ-013 flush=1 in any non-IDLE state SHALL force IDLE at the next edge with we3=0 in that cycle, done not asserted, and count retaining the writes already completed.
REQ-014 flush=1 together with start=1 in IDLE SHALL leave the block in IDLE, with start not accepted.
REQ-015 count SHALL never exceed 7.

Reset
REQ-016 When rst_n=0, the block SHALL immediately, without waiting for clk, enter IDLE with:
- address=16'h0000, pending=7'h00, idx=3'd0, count=4'd0;
- mem_rd=0, we3=0, wa3=0, wd3=0, busy=0, done=0.
REQ-017 Reset asserted mid-operation SHALL abandon the operation with no further writes. After rst_n rises, the block SHALL accept start on the first rising edge.

Verification
REQ-018 The bench SHALL cover the following directed scenarios:
- base=16'h0040, mask=8'b0000_0110, memory[0x40]=16'hAAAA, memory[0x41]=16'h5555 -> writes r1=16'hAAAA then r2=16'h5555; done in cycle 6; count=2.
- mask=8'h01 -> no mem_rd, no we3; done in cycle 2; count=0.
- base=16'hFFFF, mask=8'b1000_0010 -> reads at 16'hFFFF (to r1) then 16'h0000 (to r7); count=2.
- mask=8'hFE with flush asserted during the second WAIT -> only r1 written, no done, idle next cycle, count=1; a start applied while busy earlier in the operation is ignored.
- rst_n pulsed low for half a cycle during a WAIT with mask=8'h0E -> outputs zero immediately, no write at the next edge; a subsequent start with mask=8'h08 writes r3 only.

Source files
------------

// File: rtl/lm_writeback_seq.sv
// Load-multiple writeback sequencer: reads consecutive memory words from a
// base address and writes them into the registers selected by a mask,
// lowest index first, one register every two cycles.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; count holds the last result
// SCAN  | pick lowest pending register and issue the read, or finish
// WAIT  | read data valid; write it to register idx, advance address
// DONE  | one-cycle completion pulse, then back to IDLE
module lm_writeback_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] base,
  input  logic [7:0]  mask,
  input  logic        flush,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  input  logic [15:0] mem_rdata,
  output logic        we3,
  output logic [2:0]  wa3,
  output logic [15:0] wd3,
  output logic        busy,
  output logic        done,
  output logic [3:0]  count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  // Indexed by register number; bit 0 is never loaded since r0 holds the PC.
  logic [7:0]  pend_q, pend_d;
  logic [2:0]  idx_q, idx_d;
  logic [3:0]  count_q, count_d;
  logic [2:0]  low_idx;

  // Lowest pending register; scanning downward leaves the smallest set index.
  always_comb begin
    low_idx = 3'd0;
    for (int i = 7; i >= 1; i--) begin
      if (pend_q[i]) low_idx = 3'(i);
    end
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= 16'h0000;
      pend_q  <= 8'h00;
      idx_q   <= 3'd0;
      count_q <= 4'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      pend_q  <= pend_d;
      idx_q   <= idx_d;
      count_q <= count_d;
    end
  end

  // Next-state logic and per-state outputs.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    pend_d  = pend_q;
    idx_d   = idx_q;
    count_d = count_q;
    mem_rd  = 1'b0;
    we3     = 1'b0;
    wa3     = 3'd0;
    wd3     = 16'h0000;
    done    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // flush wins over a simultaneous start
        if (start && !flush) begin
          addr_d  = base;
          pend_d  = mask & 8'hFE;
          count_d = 4'd0;
          state_d = S_SCAN;
        end
      end

      S_SCAN: begin
        if (pend_q != 8'h00) mem_rd = 1'b1;
        if (flush) begin
          state_d = S_IDLE;
        end else if (pend_q == 8'h00) begin
          state_d = S_DONE;
        end else begin
          idx_d   = low_idx;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        wa3 = idx_q;
        wd3 = mem_rdata;
        we3 = !flush;
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          pend_d  = pend_q & ~(8'd1 << idx_q);
          addr_d  = addr_q + 16'd1;
          count_d = count_q + 4'd1;
          state_d = S_SCAN;
        end
      end

      S_DONE: begin
        done    = !flush;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign busy     = (state_q != S_IDLE);
  assign mem_addr = addr_q;
  assign count    = count_q;

endmodule

// File: tb/tb_lm_writeback_seq.sv
// Bench for lm_writeback_seq: directed table of operations, hand-written
// reset/flush sequences, and randomized operations against a schedule model.
module tb_lm_writeback_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] base;
  logic [7:0]  mask;
  logic        flush;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [15:0] mem_rdata;
  logic        we3;
  logic [2:0]  wa3;
  logic [15:0] wd3;
  logic        busy;
  logic        done;
  logic [3:0]  count;

  lm_writeback_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base      (base),
    .mask      (mask),
    .flush     (flush),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .we3       (we3),
    .wa3       (wa3),
    .wd3       (wd3),
    .busy      (busy),
    .done      (done),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;

  // Model: an accepted operation is a fixed schedule of SCAN/WAIT pairs.
  bit          m_active;
  int          m_n;
  int          m_k;
  int          m_regs [0:6];
  logic [15:0] m_base;
  logic [15:0] m_addr;
  logic [3:0]  m_count;

  logic        s_busy, s_done, s_rd, s_we;
  logic [15:0] s_addr, s_wd;
  logic [2:0]  s_wa;
  logic [3:0]  s_cnt;
  logic        rd_pend;
  logic [15:0] rd_addr;

  int          obs_done, obs_nwr, obs_nrd;
  logic [2:0]  obs_wa0, obs_wa_last;
  logic [15:0] obs_wd0, obs_wd_last, obs_rd_last;

  typedef struct {
    logic [15:0] base;
    logic [7:0]  mask;
    int          flush_at;
    bit          noise;
    int          exp_count;
    int          exp_done;
    int          exp_nwr;
    int          exp_nrd;
    logic [2:0]  exp_wa0;
    logic [2:0]  exp_wa_last;
    logic [15:0] exp_wd0;
    logic [15:0] exp_wd_last;
    logic [15:0] exp_rd_last;
  } vec_t;

  vec_t tbl [0:6];

  function automatic logic [15:0] memf(input logic [15:0] a);
    if (a == 16'h0040) return 16'hAAAA;
    if (a == 16'h0041) return 16'h5555;
    return {a[7:0], a[15:8]} ^ 16'hC3A5;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_accept(input logic [15:0] b, input logic [7:0] m);
    m_active = 1'b1;
    m_n      = 1;
    m_base   = b;
    m_k      = 0;
    for (int i = 1; i <= 7; i++) begin
      if (m[i]) begin
        m_regs[m_k] = i;
        m_k++;
      end
    end
    m_addr  = b;
    m_count = 4'd0;
  endtask

  // One clock cycle: drive inputs, check outputs at negedge, advance model.
  task automatic cyc(input logic st, input logic [15:0] b, input logic [7:0] m, input logic fl);
    logic        e_busy, e_done, e_rd, e_we;
    logic [15:0] e_addr, e_wd;
    logic [2:0]  e_wa;
    logic [3:0]  e_cnt;
    int          j;
    int          fin;
    start = st; base = b; mask = m; flush = fl;
    e_busy = 1'b0; e_done = 1'b0; e_rd = 1'b0; e_we = 1'b0;
    e_wa = 3'd0; e_wd = 16'h0000; e_addr = m_addr; e_cnt = m_count;
    if (m_active) begin
      e_busy = 1'b1;
      if (m_n <= 2 * m_k) begin
        j      = (m_n - 1) / 2;
        e_addr = m_base + 16'(j);
        e_cnt  = 4'(j);
        if (m_n % 2 == 1) begin
          e_rd = 1'b1;
        end else begin
          e_we = !fl;
          e_wa = 3'(m_regs[j]);
          e_wd = memf(e_addr);
        end
      end else begin
        e_addr = m_base + 16'(m_k);
        e_cnt  = 4'(m_k);
        if (m_n == 2 * m_k + 2) e_done = !fl;
      end
    end
    @(negedge clk);
    s_busy = busy; s_done = done; s_rd = mem_rd; s_we = we3;
    s_addr = mem_addr; s_wd = wd3; s_wa = wa3; s_cnt = count;
    chk("busy", {15'd0, s_busy}, {15'd0, e_busy});
    chk("done", {15'd0, s_done}, {15'd0, e_done});
    chk("mem_rd", {15'd0, s_rd}, {15'd0, e_rd});
    chk("mem_addr", s_addr, e_addr);
    chk("we3", {15'd0, s_we}, {15'd0, e_we});
    chk("wa3", {13'd0, s_wa}, {13'd0, e_wa});
    chk("wd3", s_wd, e_wd);
    chk("count", {12'd0, s_cnt}, {12'd0, e_cnt});
    rd_pend = mem_rd;
    rd_addr = mem_addr;
    @(posedge clk);
    #1;
    mem_rdata = rd_pend ? memf(rd_addr) : 16'h0BAD;
    if (!m_active) begin
      if (st && !fl) model_accept(b, m);
    end else if (fl) begin
      fin      = (m_n - 1) / 2;
      m_count  = 4'(fin);
      m_addr   = m_base + 16'(fin);
      m_active = 1'b0;
    end else if (m_n == 2 * m_k + 2) begin
      m_count  = 4'(m_k);
      m_addr   = m_base + 16'(m_k);
      m_active = 1'b0;
    end else begin
      m_n++;
    end
  endtask

  // Run the remainder of an accepted operation, logging what the DUT did.
  task automatic run_rest(input int flush_at, input bit noise);
    int guard;
    int n;
    obs_done = 0; obs_nwr = 0; obs_nrd = 0;
    obs_wa0 = 3'd0; obs_wa_last = 3'd0;
    obs_wd0 = 16'h0000; obs_wd_last = 16'h0000; obs_rd_last = 16'h0000;
    guard = 0;
    while (m_active && guard < 40) begin
      n = m_n;
      if (noise)
        cyc(1'($urandom), 16'($urandom), 8'($urandom), n == flush_at);
      else
        cyc(1'b0, 16'h0000, 8'h00, n == flush_at);
      if (s_done) obs_done = n;
      if (s_we) begin
        if (obs_nwr == 0) begin
          obs_wa0 = s_wa;
          obs_wd0 = s_wd;
        end
        obs_wa_last = s_wa;
        obs_wd_last = s_wd;
        obs_nwr++;
      end
      if (s_rd) begin
        obs_nrd++;
        obs_rd_last = s_addr;
      end
      guard++;
    end
    if (guard >= 40) chk("op_timeout", 16'(guard), 16'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vectors = 0; miscompares = 0;
    m_active = 1'b0; m_n = 0; m_k = 0; m_base = 16'h0; m_addr = 16'h0; m_count = 4'd0;
    for (int i = 0; i < 7; i++) m_regs[i] = 0;

    tbl[0] = '{16'h0040, 8'b0000_0110, 0, 1'b0, 2, 6, 2, 2, 3'd1, 3'd2,
               16'hAAAA, 16'h5555, 16'h0041};
    tbl[1] = '{16'h1234, 8'h01, 0, 1'b0, 0, 2, 0, 0, 3'd0, 3'd0,
               16'h0000, 16'h0000, 16'h0000};
    tbl[2] = '{16'hFFFF, 8'b1000_0010, 0, 1'b0, 2, 6, 2, 2, 3'd1, 3'd7,
               memf(16'hFFFF), memf(16'h0000), 16'h0000};
    tbl[3] = '{16'h0100, 8'hFE, 4, 1'b1, 1, 0, 1, 2, 3'd1, 3'd1,
               memf(16'h0100), memf(16'h0100), 16'h0101};
    tbl[4] = '{16'h2000, 8'hFF, 0, 1'b0, 7, 16, 7, 7, 3'd1, 3'd7,
               memf(16'h2000), memf(16'h2006), 16'h2006};
    tbl[5] = '{16'h0080, 8'b1000_0001, 0, 1'b0, 1, 4, 1, 1, 3'd7, 3'd7,
               memf(16'h0080), memf(16'h0080), 16'h0080};
    tbl[6] = '{16'h0010, 8'h04, 4, 1'b0, 1, 0, 1, 1, 3'd2, 3'd2,
               memf(16'h0010), memf(16'h0010), 16'h0010};

    rst_n = 1'b0; start = 1'b0; base = 16'h0; mask = 8'h0; flush = 1'b0;
    mem_rdata = 16'h0BAD;
    #3;
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_done", {15'd0, done}, 16'd0);
    chk("rst_mem_rd", {15'd0, mem_rd}, 16'd0);
    chk("rst_we3", {15'd0, we3}, 16'd0);
    chk("rst_mem_addr", mem_addr, 16'h0000);
    chk("rst_count", {12'd0, count}, 16'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // directed table
    for (int t = 0; t < 7; t++) begin
      cyc(1'b1, tbl[t].base, tbl[t].mask, 1'b0);
      run_rest(tbl[t].flush_at, tbl[t].noise);
      cyc(1'b0, 16'h0000, 8'h00, 1'b0);
      chk($sformatf("tbl%0d_count", t), {12'd0, s_cnt}, 16'(tbl[t].exp_count));
      chk($sformatf("tbl%0d_done_cyc", t), 16'(obs_done), 16'(tbl[t].exp_done));
      chk($sformatf("tbl%0d_nwrites", t), 16'(obs_nwr), 16'(tbl[t].exp_nwr));
      chk($sformatf("tbl%0d_nreads", t), 16'(obs_nrd), 16'(tbl[t].exp_nrd));
      chk($sformatf("tbl%0d_wa_first", t), {13'd0, obs_wa0}, {13'd0, tbl[t].exp_wa0});
      chk($sformatf("tbl%0d_wa_last", t), {13'd0, obs_wa_last}, {13'd0, tbl[t].exp_wa_last});
      chk($sformatf("tbl%0d_wd_first", t), obs_wd0, tbl[t].exp_wd0);
      chk($sformatf("tbl%0d_wd_last", t), obs_wd_last, tbl[t].exp_wd_last);
      chk($sformatf("tbl%0d_rd_last", t), obs_rd_last, tbl[t].exp_rd_last);
    end

    // flush together with start in IDLE: not accepted
    cyc(1'b1, 16'h7777, 8'hFE, 1'b1);
    cyc(1'b0, 16'h0000, 8'h00, 1'b0);
    chk("flush_start_idle_busy", {15'd0, s_busy}, 16'd0);

    // reset pulse for half a cycle during a WAIT
    cyc(1'b1, 16'h0300, 8'h0E, 1'b0);
    cyc(1'b0, 16'h0000, 8'h00, 1'b0);
    chk("pre_rst_in_wait_we3", {15'd0, we3}, 16'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy", {15'd0, busy}, 16'd0);
    chk("async_rst_we3", {15'd0, we3}, 16'd0);
    chk("async_rst_wa3", {13'd0, wa3}, 16'd0);
    chk("async_rst_wd3", wd3, 16'd0);
    chk("async_rst_mem_rd", {15'd0, mem_rd}, 16'd0);
    chk("async_rst_mem_addr", mem_addr, 16'h0000);
    chk("async_rst_count", {12'd0, count}, 16'd0);
    chk("async_rst_done", {15'd0, done}, 16'd0);
    m_active = 1'b0; m_addr = 16'h0000; m_count = 4'd0;
    @(negedge clk);
    #2;
    start = 1'b1; base = 16'h0500; mask = 8'h08; flush = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_no_write", {15'd0, we3}, 16'd0);
    chk("post_rst_first_edge_busy", {15'd0, busy}, 16'd1);
    model_accept(16'h0500, 8'h08);
    run_rest(0, 1'b0);
    cyc(1'b0, 16'h0000, 8'h00, 1'b0);
    chk("post_rst_count", {12'd0, s_cnt}, 16'd1);
    chk("post_rst_nwrites", 16'(obs_nwr), 16'd1);
    chk("post_rst_wa", {13'd0, obs_wa0}, 16'd3);
    chk("post_rst_wd", obs_wd0, memf(16'h0500));
    chk("post_rst_done_cyc", 16'(obs_done), 16'd4);

    // randomized operations
    for (int r = 0; r < 60; r++) begin
      logic [15:0] rb;
      logic [7:0]  rm;
      int          k;
      int          fa;
      rb = 16'($urandom);
      rm = 8'($urandom);
      if (r % 10 == 0) rb = 16'hFFFF - 16'($urandom_range(3, 0));
      k = 0;
      for (int i = 1; i <= 7; i++) if (rm[i]) k++;
      fa = ($urandom_range(3, 0) == 0) ? $urandom_range(2 * k + 2, 1) : 0;
      cyc(1'b1, rb, rm, 1'b0);
      run_rest(fa, 1'($urandom));
      for (int w = 0; w < $urandom_range(2, 0); w++)
        cyc(1'b0, 16'($urandom), 8'($urandom), 1'($urandom));
      if ($urandom_range(7, 0) == 0)
        cyc(1'b1, 16'($urandom), 8'($urandom), 1'b1);
    end
    cyc(1'b0, 16'h0000, 8'h00, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
